// File: rtl/audio_pkg.sv
// Shared audio-path types and constants: sample type, serial frame geometry,
// transmit state encoding and a 17-to-16 bit saturation helper.
package audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int WORD_BITS  = 16;
  localparam int FRAME_BITS = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } tx_state_t;

  // Clamp a 17-bit two's-complement value into the 16-bit sample range.
  function automatic sample_t sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) begin
      return v[16] ? 16'sh8000 : 16'sh7FFF;
    end
    return sample_t'(v[15:0]);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with occupancy, full and empty; the head word is read
// straight out of flop storage so it is valid in the same cycle it is popped.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty differ.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sample_serial_tx.sv
// Left-justified stereo serialiser to an audio DAC, fed from a small sample FIFO.
// Optional macro SAMPLE_SERIAL_TX_BIAS_REMOVE_EN subtracts BIAS (saturating) on write.
module sample_serial_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV    = 32,
  parameter int FIFO_DEPTH = 4
`ifdef SAMPLE_SERIAL_TX_BIAS_REMOVE_EN
  ,
  parameter int BIAS       = 1680
`endif
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          ready_in,
  input  sample_t                       sample_in,
  input  logic                          clear_flags_in,
  output logic                          sclk_out,
  output logic                          ws_out,
  output logic                          sd_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic                          overflow_out,
  output logic                          underflow_out
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int                BIT_W    = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_HALF = BIT_W'(WORD_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic [BIT_W-1:0]  bit_q;
  sample_t           shift_q, hold_q;
  logic              sclk_q, ws_q, ovf_q, udf_q;

  sample_t           wr_data, rd_data;
  logic              fifo_full, fifo_empty, pop;
  logic              half_tc, sclk_fall, frame_end;
  logic              overflow_evt, underflow_evt;

`ifdef SAMPLE_SERIAL_TX_BIAS_REMOVE_EN
  logic signed [16:0] debiased;
  assign debiased = {sample_in[15], sample_in} - 17'(BIAS);
  assign wr_data  = sat16(debiased);
`else
  assign wr_data  = sample_in;
`endif

  sample_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_in),
    .rst_n   (rst_in),
    .push    (ready_in),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .level   (fifo_level_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign half_tc      = (div_q == DIV_LAST);
  assign sclk_fall    = (state_q == SHIFT) && half_tc && sclk_q;
  assign frame_end    = sclk_fall && (bit_q == BIT_LAST);
  assign overflow_evt = ready_in && fifo_full && !pop;

  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    underflow_evt = 1'b0;
    unique case (state_q)
      IDLE:  if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        pop     = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (frame_end) begin
          if (!fifo_empty) pop = 1'b1;
          else             underflow_evt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      ws_q    <= 1'b0;
      shift_q <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          shift_q <= rd_data;
          hold_q  <= rd_data;
          ws_q    <= 1'b0;
          sclk_q  <= 1'b0;
          div_q   <= '0;
          bit_q   <= '0;
        end
        SHIFT: begin
          if (!half_tc) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            // Data and word select move only on the falling sclk edge.
            if (sclk_q) begin
              if (bit_q == BIT_LAST) begin
                bit_q <= '0;
                ws_q  <= 1'b0;
                if (!fifo_empty) begin
                  shift_q <= rd_data;
                  hold_q  <= rd_data;
                end else begin
                  shift_q <= hold_q;
                end
              end else if (bit_q == BIT_HALF) begin
                bit_q   <= bit_q + BIT_W'(1);
                ws_q    <= 1'b1;
                shift_q <= hold_q;
              end else begin
                bit_q   <= bit_q + BIT_W'(1);
                shift_q <= {shift_q[14:0], 1'b0};
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A flag event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= overflow_evt  | (ovf_q & ~clear_flags_in);
      udf_q <= underflow_evt | (udf_q & ~clear_flags_in);
    end
  end

  assign sclk_out      = sclk_q;
  assign ws_out        = ws_q;
  assign sd_out        = shift_q[15];
  assign overflow_out  = ovf_q;
  assign underflow_out = udf_q;

endmodule

// File: tb/tb_sample_serial_tx.sv
// Bench for sample_serial_tx: frame-position model checked every cycle, plus
// directed literal checks of latency, frame contents, flags and reset.
module tb_sample_serial_tx;

  localparam int CD    = 2;
  localparam int DEPTH = 4;
  localparam int F     = 64 * CD;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        ready_in = 1'b0;
  logic [15:0] sample_in = '0;
  logic        clear_flags_in = 1'b0;
  logic        sclk_out, ws_out, sd_out, overflow_out, underflow_out;
  logic [2:0]  fifo_level_out;

  sample_serial_tx #(
    .CLK_DIV    (CD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .ready_in       (ready_in),
    .sample_in      (sample_in),
    .clear_flags_in (clear_flags_in),
    .sclk_out       (sclk_out),
    .ws_out         (ws_out),
    .sd_out         (sd_out),
    .fifo_level_out (fifo_level_out),
    .overflow_out   (overflow_out),
    .underflow_out  (underflow_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value that ends up in the FIFO for a given input sample.
  function automatic logic [15:0] stored(input logic [15:0] s);
`ifdef SAMPLE_SERIAL_TX_BIAS_REMOVE_EN
    int d;
    d = $signed(s) - 1680;
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
    return d[15:0];
`else
    return s;
`endif
  endfunction

  // Model: queue of pending words; once running, outputs are a pure function
  // of the cycle position inside the 64*CD-cycle frame and the current word.
  typedef enum {M_IDLE, M_LOAD, M_RUN} mmode_t;
  mmode_t      mmode = M_IDLE;
  logic [15:0] mq[$];
  logic [15:0] mword = '0;
  logic [15:0] m_head;
  int          mpos = 0;
  int          m_n;
  logic        movf = 1'b0, mudf = 1'b0, m_take, m_uf, m_of;
  logic        chk_en = 1'b0;
  int          cyc = 0;

  initial forever begin
    @(posedge clk);
    if (!rst_in) begin
      mq.delete();
      mmode = M_IDLE;
      mpos  = 0;
      mword = '0;
      movf  = 1'b0;
      mudf  = 1'b0;
    end else begin
      m_n    = mq.size();
      m_take = 1'b0;
      m_uf   = 1'b0;
      m_of   = 1'b0;
      m_head = '0;
      if (mmode == M_LOAD) m_take = 1'b1;
      else if (mmode == M_RUN && mpos == F - 1) begin
        if (m_n > 0) m_take = 1'b1;
        else         m_uf = 1'b1;
      end
      if (m_take) m_head = mq.pop_front();
      if (ready_in) begin
        if (m_n < DEPTH || m_take) mq.push_back(stored(sample_in));
        else                       m_of = 1'b1;
      end
      movf = m_of | (movf & !clear_flags_in);
      mudf = m_uf | (mudf & !clear_flags_in);
      case (mmode)
        M_IDLE: if (m_n > 0) mmode = M_LOAD;
        M_LOAD: begin
          mword = m_head;
          mpos  = 0;
          mmode = M_RUN;
        end
        default: begin
          if (mpos == F - 1) begin
            mpos = 0;
            if (m_take) mword = m_head;
          end else begin
            mpos++;
          end
        end
      endcase
    end
  end

  initial forever begin
    logic e_sclk, e_ws, e_sd;
    int   b;
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      e_sclk = 1'b0;
      e_ws   = 1'b0;
      e_sd   = 1'b0;
      if (mmode == M_RUN) begin
        b      = mpos / (2 * CD);
        e_sclk = (mpos % (2 * CD)) >= CD;
        e_ws   = b >= 16;
        e_sd   = mword[15 - (b % 16)];
      end
      check($sformatf("cycle%0d", cyc),
            {24'd0, sclk_out, ws_out, sd_out, overflow_out, underflow_out, fifo_level_out},
            {24'd0, e_sclk, e_ws, e_sd, movf, mudf, 3'(mq.size())});
    end
  end

  task automatic push(input logic [15:0] s);
    @(negedge clk);
    ready_in  = 1'b1;
    sample_in = s;
    @(negedge clk);
    ready_in  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_in = 1'b0;
    repeat (n) @(negedge clk);
    rst_in = 1'b1;
  endtask

  // Starting at a frame start, collect sd/ws on each sclk rise until ws falls.
  task automatic capture_frame(output logic [31:0] sd_bits, output logic [31:0] ws_bits,
                               output int len);
    logic prev_sclk, prev_ws;
    sd_bits   = '0;
    ws_bits   = '0;
    len       = 0;
    prev_sclk = sclk_out;
    prev_ws   = ws_out;
    while (len < 400) begin
      @(negedge clk);
      len++;
      if (sclk_out && !prev_sclk) begin
        sd_bits = {sd_bits[30:0], sd_out};
        ws_bits = {ws_bits[30:0], ws_out};
      end
      if (!ws_out && prev_ws) break;
      prev_sclk = sclk_out;
      prev_ws   = ws_out;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sdb, wsb;
    int          len;
    logic [15:0] w;

    @(posedge clk);
    chk_en = 1'b1;

    // Reset and idle
    repeat (3) @(negedge clk);
    rst_in = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_serial", {29'd0, sclk_out, ws_out, sd_out}, 32'd0);
    check("idle_level", fifo_level_out, 32'd0);

    // Single word and latency
    push(16'h8001);
    check("single_level", fifo_level_out, 32'd1);
    @(negedge clk);
    check("lat_before_msb", sd_out, 32'd0);
    @(negedge clk);
    check("lat_msb", {30'd0, ws_out, sd_out}, 32'd1);
    capture_frame(sdb, wsb, len);
    check("single_sd", sdb, 32'h8001_8001);
    check("single_ws", wsb, 32'h0000_FFFF);
    check("frame_len", len, F);
    check("single_udf", underflow_out, 32'd1);

    // Underflow hold, clear, clear-vs-event collision
    do_reset(1);
    push(16'hA5A5);
    repeat (2) @(negedge clk);
    check("udf_after_reset", underflow_out, 32'd0);
    capture_frame(sdb, wsb, len);
    check("uf_frame1", sdb, 32'hA5A5_A5A5);
    check("udf_set", underflow_out, 32'd1);
    capture_frame(sdb, wsb, len);
    check("uf_frame2", sdb, 32'hA5A5_A5A5);
    @(negedge clk);
    clear_flags_in = 1'b1;
    @(negedge clk);
    clear_flags_in = 1'b0;
    check("udf_clear", underflow_out, 32'd0);
    repeat (125) @(negedge clk);
    clear_flags_in = 1'b1;
    @(negedge clk);
    clear_flags_in = 1'b0;
    check("udf_clear_collision", underflow_out, 32'd1);

    // Overflow, then push+pop while full at a frame boundary
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ready_in  = 1'b1;
      sample_in = 16'(16'h1111 * (i + 1));
    end
    @(negedge clk);
    ready_in = 1'b0;
    check("ovf_level", fifo_level_out, 32'd4);
    check("ovf_flag", overflow_out, 32'd1);
    @(negedge clk);
    clear_flags_in = 1'b1;
    @(negedge clk);
    clear_flags_in = 1'b0;
    check("ovf_clear", overflow_out, 32'd0);
    repeat (122) @(negedge clk);
    ready_in  = 1'b1;
    sample_in = 16'h7777;
    @(negedge clk);
    ready_in = 1'b0;
    check("full_pushpop_level", fifo_level_out, 32'd4);
    check("full_pushpop_noovf", overflow_out, 32'd0);
    for (int i = 0; i < 6; i++) begin
      w = (i < 4) ? 16'(16'h1111 * (i + 2)) : 16'h7777;
      capture_frame(sdb, wsb, len);
      check($sformatf("ovf_frame%0d", i), sdb, {w, w});
      check($sformatf("ovf_len%0d", i), len, F);
    end

    // Mid-frame reset
    repeat (10) @(negedge clk);
    push(16'h1234);
    check("pre_reset_level", fifo_level_out, 32'd1);
    repeat (17) @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
    check("midreset_serial", {29'd0, sclk_out, ws_out, sd_out}, 32'd0);
    check("midreset_level", fifo_level_out, 32'd0);
    check("midreset_flags", {30'd0, overflow_out, underflow_out}, 32'd0);
    rst_in = 1'b1;
    push(16'hC3C3);
    repeat (2) @(negedge clk);
    check("restart_msb", {30'd0, ws_out, sd_out}, 32'd1);
    capture_frame(sdb, wsb, len);
    check("restart_sd", sdb, 32'hC3C3_C3C3);
    check("restart_ws", wsb, 32'h0000_FFFF);

`ifdef SAMPLE_SERIAL_TX_BIAS_REMOVE_EN
    // Bias removal with saturation
    do_reset(1);
    push(16'd1680);
    repeat (2) @(negedge clk);
    capture_frame(sdb, wsb, len);
    check("bias_zero", sdb, 32'h0000_0000);
    push(16'h8000);
    capture_frame(sdb, wsb, len);
    capture_frame(sdb, wsb, len);
    check("bias_sat", sdb, 32'h8000_8000);
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
